// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/control unit for a 5-stage F/D/E/M/W pipeline: stall/bubble/set_cc generation,
// run/memory-wait/halt FSM, load-use detection over NSRC decode ports, optional perf counters.
// Controls are combinational from state and inputs. dmem_busy freezes every stage. HALT freezes all until rst.
//
// Ports: clk/rst (async active-high); D/E/M_icode, d_src, E_dstM, e_cnd, m_stat, W_stat, dmem_busy in;
//        F/D/E/M/W_stall, D/E/M_bubble, set_cc, halted, stall_cnt, bubble_cnt out.
// Optional feature macro: PIPE_PERF_CNT_EN builds the saturating stall/bubble counters;
// without it stall_cnt and bubble_cnt are tied to 0.
module pipe_hazard_ctrl #(
  parameter int unsigned       REG_W   = 4,
  parameter int unsigned       ICODE_W = 4,
  parameter int unsigned       NSRC    = 2,
  parameter int unsigned       STAT_W  = 4,
  parameter logic [REG_W-1:0]  RNONE   = REG_W'(4'hF),
  parameter int unsigned       CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ICODE_W-1:0]      D_icode,
  input  logic [ICODE_W-1:0]      E_icode,
  input  logic [ICODE_W-1:0]      M_icode,
  input  logic [NSRC*REG_W-1:0]   d_src,
  input  logic [REG_W-1:0]        E_dstM,
  input  logic                    e_cnd,
  input  logic [STAT_W-1:0]       m_stat,
  input  logic [STAT_W-1:0]       W_stat,
  input  logic                    dmem_busy,
  output logic                    F_stall,
  output logic                    D_stall,
  output logic                    E_stall,
  output logic                    M_stall,
  output logic                    W_stall,
  output logic                    D_bubble,
  output logic                    E_bubble,
  output logic                    M_bubble,
  output logic                    set_cc,
  output logic                    halted,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(11);
  localparam logic [STAT_W-1:0]  AOK      = STAT_W'(1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_w_bad;
  logic w_m_bad;
  logic w_mispredict;
  logic w_src_match;
  logic w_load_use;
  logic w_ret;

  assign w_w_bad      = (W_stat != AOK);
  assign w_m_bad      = (m_stat != AOK);
  assign w_mispredict = (E_icode == I_JXX) && !e_cnd;
  assign w_ret        = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  // Any decode source port naming the loaded register; RNONE is excluded below.
  always_comb begin
    w_src_match = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (d_src[i*REG_W +: REG_W] == E_dstM) begin
        w_src_match = 1'b1;
      end
    end
  end

  assign w_load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                      (E_dstM != RNONE) && w_src_match;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Halt only commits when memory is idle, so a busy cycle never loses the faulting write-back.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN, S_MEMWAIT: begin
        if (w_w_bad && !dmem_busy) begin
          w_state_nxt = S_HALT;
        end else if (dmem_busy) begin
          w_state_nxt = S_MEMWAIT;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign halted = (r_state == S_HALT);

  // Control outputs, first matching rule wins. A bad m_stat still lets the younger
  // hazard rules steer F/D/E. Rules are arranged so no stage gets stall and bubble together.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b1;
    if (rst) begin
      set_cc = 1'b0;
    end else if ((r_state == S_HALT) || dmem_busy) begin
      // Freeze everything; a pending bubble re-evaluates once memory is ready.
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
      set_cc  = 1'b0;
    end else if (w_w_bad) begin
      W_stall  = 1'b1;
      M_bubble = 1'b1;
      set_cc   = 1'b0;
    end else begin
      if (w_m_bad) begin
        M_bubble = 1'b1;
        set_cc   = 1'b0;
      end
      if (w_mispredict) begin
        // Wrong-path RET is squashed, so it must not stall fetch.
        D_bubble = 1'b1;
        E_bubble = 1'b1;
      end else if (w_load_use) begin
        // Decode is held, so a RET there must not be bubbled away.
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end else if (w_ret) begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_any_bubble;

  assign w_any_bubble = D_bubble | E_bubble | M_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (r_state != S_HALT) begin
      if (F_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_any_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NSRC=3, CNT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Counter expectations follow whether PIPE_PERF_CNT_EN is defined for the build.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned ICODE_W = 4;
  localparam int unsigned NSRC    = 3;
  localparam int unsigned STAT_W  = 4;
  localparam int unsigned CNT_W   = 4;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic [ICODE_W-1:0]    D_icode, E_icode, M_icode;
  logic [NSRC*REG_W-1:0] d_src;
  logic [REG_W-1:0]      E_dstM;
  logic                  e_cnd;
  logic [STAT_W-1:0]     m_stat, W_stat;
  logic                  dmem_busy;
  logic                  F_stall, D_stall, E_stall, M_stall, W_stall;
  logic                  D_bubble, E_bubble, M_bubble, set_cc, halted;
  logic [CNT_W-1:0]      stall_cnt, bubble_cnt;
  logic [8:0]            ctl;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .REG_W(REG_W), .ICODE_W(ICODE_W), .NSRC(NSRC), .STAT_W(STAT_W),
    .RNONE(4'hF), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_src(d_src), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat), .dmem_busy(dmem_busy),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
    .M_stall(M_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .halted(halted),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // {F,D,E,M,W stall, D,E,M bubble, set_cc}
  assign ctl = {F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    D_icode   = 4'h0;
    E_icode   = 4'h0;
    M_icode   = 4'h0;
    d_src     = {4'hF, 4'hF, 4'hF};
    E_dstM    = 4'hF;
    e_cnd     = 1'b1;
    m_stat    = 4'h1;
    W_stat    = 4'h1;
    dmem_busy = 1'b0;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    chk("reset_ctl",     ctl,        9'b00000_000_0);
    chk("reset_halted",  halted,     1'b0);
    chk("reset_stallc",  stall_cnt,  4'd0);
    chk("reset_bubblec", bubble_cnt, 4'd0);
    next_cycle();
    #1 rst = 1'b0;

    // Idle pipeline
    to_sample();
    chk("idle", ctl, 9'b00000_000_1);
    next_cycle();

    // Load-use hit on port 1
    E_icode = 4'h5; E_dstM = 4'h3; d_src = {4'hF, 4'h3, 4'hF};
    to_sample();
    chk("lu_port1", ctl, 9'b11000_010_1);
    next_cycle();

    // RNONE destination with RNONE sources never matches
    E_dstM = 4'hF; d_src = {4'hF, 4'hF, 4'hF};
    to_sample();
    chk("lu_rnone", ctl, 9'b00000_000_1);
    next_cycle();

    // POPQ, match only on port 2
    E_icode = 4'hB; E_dstM = 4'h4; d_src = {4'h4, 4'h0, 4'h1};
    to_sample();
    chk("lu_port2", ctl, 9'b11000_010_1);
    next_cycle();

    // Load-use with RET in decode: D_bubble stays 0
    E_icode = 4'h5; E_dstM = 4'h3; d_src = {4'hF, 4'hF, 4'h3}; D_icode = 4'h9;
    to_sample();
    chk("lu_ret", ctl, 9'b11000_010_1);
    next_cycle();

    // Mispredict overrides RET in decode
    idle_inputs();
    E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
    to_sample();
    chk("mispred_ret", ctl, 9'b00000_110_1);
    next_cycle();

    // Taken jump is not a mispredict
    e_cnd = 1'b1; D_icode = 4'h0;
    to_sample();
    chk("jxx_taken", ctl, 9'b00000_000_1);
    next_cycle();

    // RET in memory stage
    idle_inputs();
    M_icode = 4'h9;
    to_sample();
    chk("ret_in_m", ctl, 9'b10000_100_1);
    next_cycle();

    // Bad m_stat together with a mispredict
    idle_inputs();
    m_stat = 4'h3; E_icode = 4'h7; e_cnd = 1'b0;
    to_sample();
    chk("mstat_mispred", ctl, 9'b00000_111_0);
    next_cycle();

    // Memory wait during a RET bubble: 3 frozen cycles, then the bubble returns
    idle_inputs();
    D_icode = 4'h9; dmem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      to_sample();
      chk($sformatf("memwait_%0d", k), ctl, 9'b11111_000_0);
      next_cycle();
    end
    dmem_busy = 1'b0;
    to_sample();
    chk("memwait_release", ctl, 9'b10000_100_1);
    next_cycle();

    // Bad W_stat while memory busy: frozen, no halt yet
    idle_inputs();
    W_stat = 4'h2; dmem_busy = 1'b1;
    to_sample();
    chk("wbad_busy", ctl, 9'b11111_000_0);
    next_cycle();
    idle_inputs();
    to_sample();
    chk("wbad_busy_nohalt", halted, 1'b0);
    next_cycle();

    // Halt sequence
    W_stat = 4'h2;
    to_sample();
    chk("wbad_ctl",    ctl,    9'b00001_001_0);
    chk("wbad_halted", halted, 1'b0);
    next_cycle();
    idle_inputs();
    E_icode = 4'h7; e_cnd = 1'b0; dmem_busy = 1'b1;
    to_sample();
    chk("halt_ctl0",    ctl,    9'b11111_000_0);
    chk("halt_halted0", halted, 1'b1);
    next_cycle();
    idle_inputs();
    D_icode = 4'h9;
    to_sample();
    chk("halt_ctl1",    ctl,    9'b11111_000_0);
    chk("halt_halted1", halted, 1'b1);
    next_cycle();

    // Async reset mid-halt
    #1 rst = 1'b1;
    #1;
    chk("rst_halted", halted, 1'b0);
    chk("rst_ctl",    ctl,    9'b00000_000_0);
    #1 rst = 1'b0;
    to_sample();
    chk("after_rst_ret", ctl, 9'b10000_100_1);
    next_cycle();

    // Counters: load-use held after a reset pulse
    rst = 1'b1;
    idle_inputs();
    E_icode = 4'h5; E_dstM = 4'h3; d_src = {4'hF, 4'hF, 4'h3};
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    to_sample();
    chk("stallc_5",  stall_cnt,  PERF ? 4'd5 : 4'd0);
    chk("bubblec_5", bubble_cnt, PERF ? 4'd5 : 4'd0);
    repeat (15) @(posedge clk);
    to_sample();
    chk("stallc_sat",  stall_cnt,  PERF ? 4'd15 : 4'd0);
    chk("bubblec_sat", bubble_cnt, PERF ? 4'd15 : 4'd0);

    // Counters freeze in HALT
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    W_stat = 4'h2;
    #2 rst = 1'b0;
    next_cycle();
    W_stat = 4'h1;
    repeat (5) @(posedge clk);
    to_sample();
    chk("halt_cnt_halted", halted,     1'b1);
    chk("halt_stallc",     stall_cnt,  4'd0);
    chk("halt_bubblec",    bubble_cnt, PERF ? 4'd1 : 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised next-generation hazard/control unit for the 5-stage pipelined processor (F/D/E/M/W).
- Generates per-stage stall/bubble controls from stage icodes, register IDs, branch outcome and status codes.
- Adds a sequential run/memory-wait/halt FSM, RNONE-aware load-use detection, N decode source ports, exception handling and saturating stall/bubble counters.
- Sits beside the pipeline registers; all outputs feed their stall/bubble inputs and the CC register.

Parameters:
REG_W, 4, register-ID width
ICODE_W, 4, instruction-code width
NSRC, 2, number of decode source-register ports checked for load-use (≥1)
STAT_W, 4, status-code width; AOK = 1
RNONE, 4'hF, "no register" ID; never matches
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
D_icode  in  ICODE_W  decode-stage icode
E_icode  in  ICODE_W  execute-stage icode
M_icode  in  ICODE_W  memory-stage icode
d_src  in  NSRC*REG_W  decode source IDs; port i at bits [i*REG_W +: REG_W]
E_dstM  in  REG_W  execute-stage memory destination
e_cnd  in  1  execute condition result
m_stat  in  STAT_W  memory-stage status
W_stat  in  STAT_W  write-back-stage status
dmem_busy  in  1  data memory not ready this cycle
F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  hold stage register
D_bubble, E_bubble, M_bubble  out  1 each  inject nop into stage register
set_cc  out  1  enable CC update
halted  out  1  registered; 1 in HALT state
stall_cnt  out  CNT_W  cycles with F_stall=1
bubble_cnt  out  CNT_W  cycles with any bubble=1

Behaviour:
- Reset: clk and asynchronous active-high rst. While rst=1: state=RUN, halted=0, counters=0, all stall/bubble outputs=0, set_cc=0.
- Icode constants: JXX=7, MRMOVQ=5, POPQ=B, RET=9.
- FSM, registered:
  - RUN→MEMWAIT when dmem_busy=1.
  - MEMWAIT→RUN when dmem_busy=0.
  - RUN or MEMWAIT→HALT on an edge where W_stat≠AOK and dmem_busy=0.
  - HALT is sticky until rst.
- Control outputs are combinational from state and inputs. Defaults: all 0, set_cc=1. Priority, first match wins:
  1. state=HALT: all five stalls=1, bubbles=0, set_cc=0.
  2. dmem_busy=1, any state except HALT: all five stalls=1, set_cc=0. A pending bubble is deferred, not lost.
  3. W_stat≠AOK: W_stall=1, M_bubble=1, set_cc=0.
  4. m_stat≠AOK: M_bubble=1, set_cc=0. Younger hazard rules 5–7 are still evaluated for F/D/E controls.
  5. Mispredict, E_icode=JXX and e_cnd=0: D_bubble=1, E_bubble=1. Overrides RET (combination A).
  6. Load-use: E_icode∈{MRMOVQ,POPQ}, E_dstM≠RNONE, and E_dstM equals any d_src[i], i<NSRC. Then F_stall=D_stall=1, E_bubble=1. D_bubble is forced 0 even if RET is present (combination B).
  7. RET in D, E or M: F_stall=1, D_bubble=1.
- A stall and a bubble are never both 1 for the same stage.
- Counters advance on clk only when state≠HALT and rst=0; both saturate at 2^CNT_W−1.
- Reset asserted mid-MEMWAIT or in HALT returns to RUN asynchronously.
- halted rises on the edge after the W_stat≠AOK cycle.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: stall_cnt and bubble_cnt are live saturating counters as above.
- Undefined: counter registers are not built; stall_cnt and bubble_cnt are tied to 0. Control behaviour is identical either way.

Test Plan:
- Load-use, port 1: E_icode=5, E_dstM=3, d_src={port1=3, port0=F} → F_stall=D_stall=E_bubble=1, D_bubble=0. Repeat with E_dstM=F, d_src port0=F → no stall.
- Mispredict plus RET: E_icode=7, e_cnd=0, D_icode=9 → D_bubble=E_bubble=1, F_stall=0. Next cycle E_icode=0, M_icode=9 → F_stall=1, D_bubble=1.
- Memory wait: dmem_busy=1 for 3 cycles during a RET bubble → all stalls=1 and no bubbles for 3 cycles. FSM returns to RUN; D_bubble reappears on the 4th cycle.
- Halt: W_stat=2 for one cycle → W_stall=1, M_bubble=1, set_cc=0 that cycle. halted=1 on the next edge; all stalls=1 thereafter while inputs toggle. rst pulse mid-halt → halted=0 immediately.
- Counters, with PIPE_PERF_CNT_EN and CNT_W=4: 20 cycles of F_stall=1 → stall_cnt=15 (saturated). Without the macro → stall_cnt=0.
- NSRC=3: a match only on port 2 (E_icode=B, E_dstM=4, d_src port2=4) → load-use stall asserted.
